// File: rtl/xpb_table_gen_if.sv
// Control/status and table write port bundle for the xpb reduction table generator.
// The slave side is the generator; the master side is whoever loads config and owns the table RAM.
interface xpb_table_gen_if #(
  parameter int WIDTH   = 1024,
  parameter int ADDR_W  = 5,
  parameter int SHIFT_W = 11
);
  logic               i_start;
  logic [WIDTH-1:0]   i_modulus;
  logic [WIDTH-1:0]   i_seed;
  logic [SHIFT_W-1:0] i_shiftAmt;
  logic               o_busy;
  logic               o_done;
  logic               o_err;
  logic               o_wrEn;
  logic [ADDR_W-1:0]  o_wrAddr;
  logic [WIDTH-1:0]   o_wrData;

  modport slave (
    input  i_start, i_modulus, i_seed, i_shiftAmt,
    output o_busy, o_done, o_err, o_wrEn, o_wrAddr, o_wrData
  );

  modport master (
    output i_start, i_modulus, i_seed, i_shiftAmt,
    input  o_busy, o_done, o_err, o_wrEn, o_wrAddr, o_wrData
  );
endinterface

// File: rtl/xpb_table_gen.sv
// Runtime generator for the xpb lookup table: entry[k] = (k * seed * 2^shift) mod N,
// written to the table RAM as 2^ADDR_W consecutive registered writes.
module xpb_table_gen #(
  parameter int WIDTH   = 1024,
  parameter int ADDR_W  = 5,
  parameter int SHIFT_W = 11
) (
  input  logic            clk,
  input  logic            reset,
  xpb_table_gen_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DBL, GEN, FIN} state_t;

  state_t             r_state, w_nextState;
  logic [WIDTH-1:0]   r_nMod, w_nMod;
  logic [WIDTH:0]     r_base, w_base;
  logic [WIDTH:0]     r_acc, w_acc;
  logic [SHIFT_W-1:0] r_shCnt, w_shCnt;
  logic [ADDR_W:0]    r_k, w_k;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic               r_err, w_err;
  logic               r_wrEn, w_wrEn;
  logic [ADDR_W-1:0]  r_wrAddr, w_wrAddr;
  logic [WIDTH-1:0]   r_wrData, w_wrData;

  logic [WIDTH:0]     w_nExt;
  logic [WIDTH:0]     w_dbl;
  logic [WIDTH:0]     w_sum;

  // Operands are always < N, so a doubling or a sum is < 2N and one conditional subtract reduces it.
  assign w_nExt = {1'b0, r_nMod};
  assign w_dbl  = {r_base[WIDTH-1:0], 1'b0};
  assign w_sum  = r_acc + r_base;

  always_comb begin
    w_nextState = r_state;
    w_nMod      = r_nMod;
    w_base      = r_base;
    w_acc       = r_acc;
    w_shCnt     = r_shCnt;
    w_k         = r_k;
    w_err       = r_err;
    w_done      = 1'b0;
    w_wrEn      = 1'b0;
    w_wrAddr    = r_wrAddr;
    w_wrData    = r_wrData;

    case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          w_nMod  = bus.i_modulus;
          w_base  = {1'b0, bus.i_seed};
          w_shCnt = bus.i_shiftAmt;
          w_acc   = '0;
          w_k     = '0;
          w_err   = 1'b0;
          if (bus.i_seed >= bus.i_modulus) begin
            w_err       = 1'b1;
            w_nextState = FIN;
          end else if (bus.i_shiftAmt != '0) begin
            w_nextState = DBL;
          end else begin
            w_nextState = GEN;
          end
        end
      end
      DBL: begin
        w_base  = (w_dbl >= w_nExt) ? (w_dbl - w_nExt) : w_dbl;
        w_shCnt = r_shCnt - SHIFT_W'(1);
        if (r_shCnt == SHIFT_W'(1)) w_nextState = GEN;
      end
      GEN: begin
        w_wrEn   = 1'b1;
        w_wrAddr = r_k[ADDR_W-1:0];
        w_wrData = r_acc[WIDTH-1:0];
        w_acc    = (w_sum >= w_nExt) ? (w_sum - w_nExt) : w_sum;
        w_k      = r_k + (ADDR_W+1)'(1);
        if (r_k[ADDR_W-1:0] == '1) w_nextState = FIN;
      end
      FIN: begin
        w_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase

    w_busy = (w_nextState != IDLE);
  end

  // All outputs are registered, so each write lands one cycle after the GEN cycle that computed it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_nMod   <= '0;
      r_base   <= '0;
      r_acc    <= '0;
      r_shCnt  <= '0;
      r_k      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_wrEn   <= 1'b0;
      r_wrAddr <= '0;
      r_wrData <= '0;
    end else begin
      r_state  <= w_nextState;
      r_nMod   <= w_nMod;
      r_base   <= w_base;
      r_acc    <= w_acc;
      r_shCnt  <= w_shCnt;
      r_k      <= w_k;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_err    <= w_err;
      r_wrEn   <= w_wrEn;
      r_wrAddr <= w_wrAddr;
      r_wrData <= w_wrData;
    end
  end

  assign bus.o_busy   = r_busy;
  assign bus.o_done   = r_done;
  assign bus.o_err    = r_err;
  assign bus.o_wrEn   = r_wrEn;
  assign bus.o_wrAddr = r_wrAddr;
  assign bus.o_wrData = r_wrData;

endmodule
